// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and header/word geometry.
package prog_loader_pkg;

   localparam int WORD_BYTES = 4;
   localparam int LEN_BYTES  = 4;
   localparam int LEN_W      = 32;
   localparam int CHK_W      = 8;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CHK  = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// 4-byte MSB-first shift register; word_next/word_full present the completed word
// combinationally in the cycle its last byte is accepted.
module prog_loader_byte_packer
   import prog_loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        shift,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        word_full
);

   // Only the three older bytes need storage; the newest comes straight from byte_in.
   logic [23:0] word_q;
   logic [1:0]  idx;

   assign word_next = {word_q, byte_in};
   assign word_full = shift && (idx == 2'(WORD_BYTES - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         word_q <= '0;
         idx    <= '0;
      end else if (clear) begin
         word_q <= '0;
         idx    <= '0;
      end else if (shift) begin
         word_q <= word_next[23:0];
         idx    <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Host-to-core program loader: parses a length header, writes big-endian words to
// instruction memory and holds the pipeline until the image checksum passes.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   LEN    | collecting the 4-byte word count
//   DATA   | collecting image words, writing imem
//   CHK    | collecting the checksum byte
//   DONE   | image good, pipeline released
//   ERR    | bad length or checksum, pipeline held
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int          MAX_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [31:0] words_loaded
);

   state_t             state, state_next;
   logic [LEN_W-1:0]   n_words;
   logic [CHK_W-1:0]   checksum;
   logic               load_start;
   logic               fire;
   logic               pk_shift;
   logic               pk_full;
   logic [31:0]        pk_word;

   assign byte_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
   assign fire       = byte_valid && byte_ready;
   assign pk_shift   = fire && ((state == S_LEN) || (state == S_DATA));

   prog_loader_byte_packer u_packer (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (load_start),
      .shift     (pk_shift),
      .byte_in   (byte_in),
      .word_next (pk_word),
      .word_full (pk_full)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_start = 1'b0;
      cpu_hold   = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_LEN;
               load_start = 1'b1;
            end
         end
         S_LEN: begin
            if (pk_full) begin
               if (pk_word == '0)                    state_next = S_CHK;
               else if (pk_word > 32'(MAX_WORDS))    state_next = S_ERR;
               else                                  state_next = S_DATA;
            end
         end
         S_DATA: begin
            // The previous word's strobe has already bumped words_loaded by now.
            if (pk_full && (words_loaded + 32'd1 == n_words)) state_next = S_CHK;
         end
         S_CHK: begin
            if (fire) state_next = (CHK_W'(checksum + byte_in) == '0) ? S_DONE : S_ERR;
         end
         S_DONE: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
            if (start) begin
               state_next = S_LEN;
               load_start = 1'b1;
            end
         end
         S_ERR: begin
            error = 1'b1;
            if (start) begin
               state_next = S_LEN;
               load_start = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         n_words      <= '0;
         checksum     <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= BASE_ADDR;
         imem_wdata   <= '0;
         words_loaded <= '0;
      end else begin
         imem_we <= (state == S_DATA) && pk_full;
         if (load_start) begin
            n_words      <= '0;
            checksum     <= '0;
            imem_addr    <= BASE_ADDR;
            words_loaded <= '0;
         end else begin
            if ((state == S_LEN) && pk_full) n_words <= pk_word;
            if ((state == S_DATA) && fire)   checksum <= checksum + byte_in;
            if ((state == S_DATA) && pk_full) imem_wdata <= pk_word;
            if (imem_we) begin
               imem_addr    <= imem_addr + 32'd4;
               words_loaded <= words_loaded + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader against a byte-list reference model.
module tb_prog_loader;

   localparam int          MAX_W = 16;
   localparam logic [31:0] BASE  = 32'h0;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  byte_in = '0;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [31:0] words_loaded;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  img[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   prog_loader #(.MAX_WORDS(MAX_W), .BASE_ADDR(BASE)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (imem_we) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic make_img(input int unsigned n, input bit good);
      int unsigned sum = 0;
      logic [31:0] hdr = n;
      img.delete();
      img.push_back(hdr[31:24]);
      img.push_back(hdr[23:16]);
      img.push_back(hdr[15:8]);
      img.push_back(hdr[7:0]);
      if (n <= MAX_W) begin
         for (int i = 0; i < 4 * n; i++) begin
            logic [7:0] b = 8'($urandom);
            img.push_back(b);
            sum += b;
         end
         if (good) img.push_back(8'((256 - (sum % 256)) % 256));
         else      img.push_back(8'($urandom));
      end
   endtask

   // Offer img[0..cnt-1]; pv is percent chance of byte_valid, poke is the byte index
   // during which start is held high (ignored mid-load).
   task automatic send_bytes(input int cnt, input int pv, input int poke);
      for (int i = 0; i < cnt; i++) begin
         int waited = 0;
         forever begin
            @(negedge clock);
            byte_valid = ($urandom_range(99) < pv);
            byte_in    = byte_valid ? img[i] : 8'($urandom);
            start      = (i == poke);
            if (byte_valid && byte_ready) break;
            waited++;
            if (waited > 200) begin
               check("byte_timeout", 1, 0);
               byte_valid = 1'b0;
               start      = 1'b0;
               return;
            end
         end
      end
      @(negedge clock);
      byte_valid = 1'b0;
      start      = 1'b0;
      byte_in    = 8'($urandom);
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("start_hold", cpu_hold, 1);
      check("start_done", done, 0);
      check("start_err", error, 0);
      check("start_ready", byte_ready, 1);
      check("start_wl", words_loaded, 0);
   endtask

   task automatic run_load(input int pv, input int poke);
      int unsigned n;
      int unsigned sum = 0;
      bit          bad, good;
      n = {img[0], img[1], img[2], img[3]};
      bad = (n > MAX_W);
      if (!bad) begin
         for (int i = 4; i < img.size(); i++) sum += img[i];
      end
      good = !bad && (sum % 256 == 0);
      wr_addr_q.delete();
      wr_data_q.delete();
      pulse_start();
      send_bytes(bad ? 4 : img.size(), pv, poke);
      check("end_done", done, good);
      check("end_error", error, !good);
      check("end_hold", cpu_hold, !good);
      check("end_ready", byte_ready, 0);
      repeat (2) @(negedge clock);
      check("nwrites", wr_addr_q.size(), bad ? 0 : n);
      check("words_loaded", words_loaded, bad ? 0 : n);
      if (!bad) begin
         for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
            check("wr_addr", wr_addr_q[k], BASE + 32'(4 * k));
            check("wr_data", wr_data_q[k],
                  {img[4+4*k], img[5+4*k], img[6+4*k], img[7+4*k]});
         end
      end
      check("hold_done", done, good);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with random inputs
      repeat (5) begin
         @(negedge clock);
         start      = 1'($urandom);
         byte_valid = 1'($urandom);
         byte_in    = 8'($urandom);
      end
      check("rst_hold", cpu_hold, 1);
      check("rst_ready", byte_ready, 0);
      check("rst_we", imem_we, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_addr", imem_addr, BASE);
      check("rst_wl", words_loaded, 0);
      start = 1'b0; byte_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Nominal image with bad then good checksum
      img = {8'h00, 8'h00, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load(100, -1);
      check("nom_w0", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'h24080005);
      img[12] = 8'hCF;
      run_load(100, -1);

      // Source backpressure on the same image
      run_load(50, -1);

      // Header bounds
      make_img(0, 1);
      run_load(100, -1);
      make_img(MAX_W + 1, 1);
      run_load(100, -1);
      make_img(MAX_W, 1);
      run_load(80, -1);

      // Reset after 6th byte
      make_img(3, 1);
      pulse_start();
      send_bytes(6, 100, -1);
      reset_n = 1'b0;
      wr_addr_q.delete();
      repeat (4) begin
         @(negedge clock);
         byte_valid = 1'($urandom);
         byte_in    = 8'($urandom);
      end
      check("mid_rst_ready", byte_ready, 0);
      check("mid_rst_wl", words_loaded, 0);
      byte_valid = 1'b0;
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      check("mid_rst_nwr", wr_addr_q.size(), 0);
      check("mid_rst_idle_ready", byte_ready, 0);
      run_load(100, -1);

      // Restart from DONE, start held during DATA
      make_img(4, 1);
      run_load(100, -1);
      make_img(3, 1);
      run_load(100, 6);

      // Random images
      for (int t = 0; t < 12; t++) begin
         int unsigned n = ($urandom_range(7) == 0) ? MAX_W + 1 + $urandom_range(100)
                                                    : $urandom_range(MAX_W);
         make_img(n, $urandom_range(3) != 0);
         run_load($urandom_range(100, 30), ($urandom_range(1) == 1) ? 5 : -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
